// File: rtl/rob_multiport.sv
// rtl/rob_multiport.sv - multi-port reorder buffer; optional ROB_CDB_BYPASS_EN forwards same-cycle CDB results to lookups
module rob_multiport #(
    parameter int DEPTH     = 16,
    parameter int CDB_PORTS = 2,
    parameter int IDX_W     = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alloc_valid,
    input  logic [4:0]                 alloc_rd_addr,
    input  logic [2:0]                 alloc_op_type,
    output logic                       alloc_ready,
    output logic [IDX_W-1:0]           alloc_idx,
    input  logic [CDB_PORTS-1:0]       cdb_valid,
    input  logic [CDB_PORTS*IDX_W-1:0] cdb_rob_idx,
    input  logic [CDB_PORTS*32-1:0]    cdb_data,
    output logic                       commit_valid,
    input  logic                       commit_ready,
    output logic [4:0]                 commit_rd_addr,
    output logic [31:0]                commit_rd_data,
    output logic [IDX_W-1:0]           commit_rob_idx,
    input  logic                       flush,
    input  logic [2*IDX_W-1:0]         src_idx,
    output logic [1:0]                 src_done,
    output logic [2*32-1:0]            src_data,
    output logic [IDX_W:0]             count
);

    typedef enum logic {
        ROB_WAIT = 1'b0,
        ROB_DONE = 1'b1
    } status_e;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ALU  = 3'd1,
        OP_MUL  = 3'd2,
        OP_DIV  = 3'd3,
        OP_BR   = 3'd4,
        OP_MEM  = 3'd5
    } types_t;

    logic [DEPTH-1:0] valid_q;
    status_e          status_q [DEPTH];
    types_t           op_q     [DEPTH];
    logic [4:0]       rd_q     [DEPTH];
    logic [31:0]      data_q   [DEPTH];

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    logic [IDX_W:0]   head_q, head_d;
    logic [IDX_W:0]   tail_q, tail_d;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             full;
    logic             alloc_fire;
    logic             commit_fire;

    logic [DEPTH-1:0] cdb_hit;
    logic [31:0]      cdb_wdata [DEPTH];

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    // Dispatch-side status is purely registered: a same-cycle commit never frees a slot early.
    assign alloc_ready = !full;
    assign alloc_idx   = tail_idx;
    assign count       = tail_q - head_q;

    assign commit_valid   = valid_q[head_idx] && (status_q[head_idx] == ROB_DONE);
    assign commit_rd_addr = rd_q[head_idx];
    assign commit_rd_data = data_q[head_idx];
    assign commit_rob_idx = head_idx;

    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = commit_valid && commit_ready;

    // Resolve CDB ports per entry; iterating high to low lets the lowest-numbered port win.
    always_comb begin
        cdb_hit = '0;
        for (int e = 0; e < DEPTH; e++) begin
            cdb_wdata[e] = '0;
            for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                if (cdb_valid[p] && (cdb_rob_idx[p*IDX_W +: IDX_W] == IDX_W'(e))) begin
                    cdb_hit[e]   = valid_q[e];
                    cdb_wdata[e] = cdb_data[p*32 +: 32];
                end
            end
        end
    end

    // Next-state pointers; flush forces both back to slot zero.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (commit_fire) begin
                head_d = head_q + 1'b1;
            end
            if (alloc_fire) begin
                tail_d = tail_q + 1'b1;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage: flush drops everything, otherwise CDB, commit and alloc touch disjoint slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                status_q[e] <= ROB_WAIT;
                op_q[e]     <= OP_NONE;
                rd_q[e]     <= '0;
                data_q[e]   <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (cdb_hit[e]) begin
                    status_q[e] <= ROB_DONE;
                    data_q[e]   <= cdb_wdata[e];
                end
            end
            if (commit_fire) begin
                valid_q[head_idx] <= 1'b0;
            end
            if (alloc_fire) begin
                valid_q[tail_idx]  <= 1'b1;
                status_q[tail_idx] <= ROB_WAIT;
                op_q[tail_idx]     <= types_t'(alloc_op_type);
                rd_q[tail_idx]     <= alloc_rd_addr;
                data_q[tail_idx]   <= '0;
            end
        end
    end

    // Operand lookups for rs1/rs2, optionally forwarding results arriving on the CDB this cycle.
    always_comb begin
        src_done = '0;
        src_data = '0;
        for (int k = 0; k < 2; k++) begin
            src_done[k]         = valid_q[src_idx[k*IDX_W +: IDX_W]] &&
                                  (status_q[src_idx[k*IDX_W +: IDX_W]] == ROB_DONE);
            src_data[k*32 +: 32] = data_q[src_idx[k*IDX_W +: IDX_W]];
`ifdef ROB_CDB_BYPASS_EN
            if (cdb_hit[src_idx[k*IDX_W +: IDX_W]]) begin
                src_done[k]          = 1'b1;
                src_data[k*32 +: 32] = cdb_wdata[src_idx[k*IDX_W +: IDX_W]];
            end
`endif
        end
    end

    // op_type is retained per entry for debug visibility; nothing in this block consumes it.
    logic unused_op_parity;
    always_comb begin
        unused_op_parity = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
            unused_op_parity = unused_op_parity ^ (^op_q[e]);
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
// tb/tb_rob_multiport.sv - self-checking bench for rob_multiport against a queue-based reference model
module tb_rob_multiport;

    localparam int DEPTH     = 16;
    localparam int CDB_PORTS = 2;
    localparam int IDX_W     = 4;

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       alloc_valid;
    logic [4:0]                 alloc_rd_addr;
    logic [2:0]                 alloc_op_type;
    logic                       alloc_ready;
    logic [IDX_W-1:0]           alloc_idx;
    logic [CDB_PORTS-1:0]       cdb_valid;
    logic [CDB_PORTS*IDX_W-1:0] cdb_rob_idx;
    logic [CDB_PORTS*32-1:0]    cdb_data;
    logic                       commit_valid;
    logic                       commit_ready;
    logic [4:0]                 commit_rd_addr;
    logic [31:0]                commit_rd_data;
    logic [IDX_W-1:0]           commit_rob_idx;
    logic                       flush;
    logic [2*IDX_W-1:0]         src_idx;
    logic [1:0]                 src_done;
    logic [2*32-1:0]            src_data;
    logic [IDX_W:0]             count;

    int total = 0;
    int bad   = 0;

    rob_multiport #(.DEPTH(DEPTH), .CDB_PORTS(CDB_PORTS)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_rd_addr(alloc_rd_addr), .alloc_op_type(alloc_op_type),
        .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
        .commit_valid(commit_valid), .commit_ready(commit_ready),
        .commit_rd_addr(commit_rd_addr), .commit_rd_data(commit_rd_data), .commit_rob_idx(commit_rob_idx),
        .flush(flush), .src_idx(src_idx), .src_done(src_done), .src_data(src_data), .count(count)
    );

    always #5 clk = ~clk;

    // Reference model: program-ordered queue of in-flight entries plus a free-running tail counter.
    typedef struct {
        int          idx;
        logic [4:0]  rd;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t mq[$];
    int   m_tail;

    function automatic int m_find(int idx);
        foreach (mq[i]) if (mq[i].idx == idx) return i;
        return -1;
    endfunction

    task automatic model_edge();
        bit             do_commit;
        bit             do_alloc;
        bit [DEPTH-1:0] taken;
        int             pos;
        int             tidx;
        ent_t           e;
        if (flush) begin
            mq.delete();
            m_tail = 0;
            return;
        end
        do_commit = (mq.size() > 0) && mq[0].done && commit_ready;
        do_alloc  = alloc_valid && (mq.size() < DEPTH);
        taken     = '0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            if (cdb_valid[p]) begin
                tidx = int'(cdb_rob_idx[p*IDX_W +: IDX_W]);
                if (!taken[tidx]) begin
                    taken[tidx] = 1'b1;
                    pos = m_find(tidx);
                    if (pos >= 0) begin
                        mq[pos].done = 1'b1;
                        mq[pos].data = cdb_data[p*32 +: 32];
                    end
                end
            end
        end
        if (do_commit) void'(mq.pop_front());
        if (do_alloc) begin
            e.idx  = m_tail % DEPTH;
            e.rd   = alloc_rd_addr;
            e.done = 1'b0;
            e.data = '0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % (2 * DEPTH);
        end
    endtask

    task automatic idle();
        alloc_valid   = 1'b0;
        alloc_rd_addr = '0;
        alloc_op_type = '0;
        cdb_valid     = '0;
        cdb_rob_idx   = '0;
        cdb_data      = '0;
        commit_ready  = 1'b0;
        flush         = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        idle();
        #2;
        rst_n = 1'b0;
        mq.delete();
        m_tail = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            alloc_valid   = 1'b1;
            alloc_rd_addr = 5'(i + 1);
            alloc_op_type = 3'(1 + (i % 5));
            tick();
        end
        alloc_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        src_idx = 8'h53;
        rst_n   = 1'b0;
        #3;
        total++; if (alloc_ready !== 1'b1) begin bad++; $display("FAIL reset_alloc_ready got=%0b exp=1", alloc_ready); end
        total++; if (alloc_idx !== 4'd0) begin bad++; $display("FAIL reset_alloc_idx got=%0d exp=0", alloc_idx); end
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL reset_commit_valid got=%0b exp=0", commit_valid); end
        total++; if ({commit_rd_addr, commit_rd_data, commit_rob_idx} !== '0) begin bad++; $display("FAIL reset_commit_fields got=%0h/%0h/%0d exp=0", commit_rd_addr, commit_rd_data, commit_rob_idx); end
        total++; if ({src_done, src_data} !== '0) begin bad++; $display("FAIL reset_src got=%0b/%0h exp=0", src_done, src_data); end
        total++; if (count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mq.delete();
        m_tail = 0;
        fill(3);
        total++; if (count !== 5'd3) begin bad++; $display("FAIL pre_midreset_count got=%0d exp=3", count); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (count !== 5'd0 || alloc_idx !== 4'd0) begin bad++; $display("FAIL async_reset got count=%0d idx=%0d exp=0/0", count, alloc_idx); end
        mq.delete();
        m_tail = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        alloc_valid = 1'b1;
        alloc_rd_addr = 5'd9;
        tick();
        idle();
        total++; if (count !== 5'd1) begin bad++; $display("FAIL first_alloc_after_reset got=%0d exp=1", count); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc_valid   = 1'b1;
            alloc_rd_addr = 5'(i + 1);
            #1;
            total++; if (alloc_idx !== 4'(i) || alloc_ready !== 1'b1) begin bad++; $display("FAIL fill_step%0d got idx=%0d rdy=%0b exp=%0d/1", i, alloc_idx, alloc_ready, i); end
            tick();
        end
        total++; if (alloc_ready !== 1'b0 || count !== 5'd16) begin bad++; $display("FAIL fill_full got rdy=%0b cnt=%0d exp=0/16", alloc_ready, count); end
        alloc_rd_addr = 5'd17;
        tick();
        idle();
        total++; if (count !== 5'd16 || alloc_idx !== 4'd0) begin bad++; $display("FAIL fill_17th_refused got cnt=%0d idx=%0d exp=16/0", count, alloc_idx); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        fill(4);
        cdb_valid   = 2'b11;
        cdb_rob_idx = {4'd0, 4'd2};
        cdb_data    = {32'h0000_0001, 32'hAAAA_0002};
        #1;
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL ooo_same_cycle_commit got=%0b exp=0", commit_valid); end
        tick();
        idle();
        total++; if (commit_valid !== 1'b1 || commit_rd_data !== 32'h1 || commit_rob_idx !== 4'd0 || commit_rd_addr !== 5'd1) begin bad++; $display("FAIL ooo_head_commit got v=%0b d=%0h i=%0d rd=%0d exp=1/1/0/1", commit_valid, commit_rd_data, commit_rob_idx, commit_rd_addr); end
        commit_ready = 1'b1;
        tick();
        total++; if (commit_valid !== 1'b0 || commit_rob_idx !== 4'd1) begin bad++; $display("FAIL ooo_idx1_blocks got v=%0b i=%0d exp=0/1", commit_valid, commit_rob_idx); end
        tick();
        total++; if (count !== 5'd3) begin bad++; $display("FAIL ooo_blocked_count got=%0d exp=3", count); end
        cdb_valid   = 2'b01;
        cdb_rob_idx = {4'd0, 4'd1};
        cdb_data    = {32'h0, 32'h0000_0055};
        tick();
        cdb_valid = 2'b00;
        total++; if (commit_valid !== 1'b1 || commit_rob_idx !== 4'd1 || commit_rd_data !== 32'h55) begin bad++; $display("FAIL ooo_idx1_done got v=%0b i=%0d d=%0h exp=1/1/55", commit_valid, commit_rob_idx, commit_rd_data); end
        tick();
        total++; if (commit_valid !== 1'b1 || commit_rob_idx !== 4'd2 || commit_rd_data !== 32'hAAAA_0002) begin bad++; $display("FAIL ooo_idx2_commit got v=%0b i=%0d d=%0h exp=1/2/aaaa0002", commit_valid, commit_rob_idx, commit_rd_data); end
        tick();
        idle();
        total++; if (commit_valid !== 1'b0 || count !== 5'd1) begin bad++; $display("FAIL ooo_idx3_pending got v=%0b cnt=%0d exp=0/1", commit_valid, count); end
    endtask

    task automatic test_same_index();
        cdb_valid   = 2'b11;
        cdb_rob_idx = {4'd3, 4'd3};
        cdb_data    = {32'h0000_0022, 32'h0000_0011};
        tick();
        idle();
        src_idx = {4'd0, 4'd3};
        #1;
        total++; if (src_done[0] !== 1'b1 || src_data[31:0] !== 32'h11) begin bad++; $display("FAIL same_idx_lookup got done=%0b d=%0h exp=1/11", src_done[0], src_data[31:0]); end
        total++; if (commit_valid !== 1'b1 || commit_rd_data !== 32'h11) begin bad++; $display("FAIL same_idx_commit got v=%0b d=%0h exp=1/11", commit_valid, commit_rd_data); end
    endtask

    task automatic test_full_commit_alloc();
        do_reset();
        fill(DEPTH);
        cdb_valid   = 2'b01;
        cdb_rob_idx = {4'd0, 4'd0};
        cdb_data    = {32'h0, 32'h0000_0077};
        tick();
        idle();
        commit_ready  = 1'b1;
        alloc_valid   = 1'b1;
        alloc_rd_addr = 5'd20;
        #1;
        total++; if (alloc_ready !== 1'b0 || commit_valid !== 1'b1) begin bad++; $display("FAIL full_pre got rdy=%0b cv=%0b exp=0/1", alloc_ready, commit_valid); end
        tick();
        total++; if (count !== 5'd15 || alloc_idx !== 4'd0 || alloc_ready !== 1'b1) begin bad++; $display("FAIL full_commit_only got cnt=%0d idx=%0d rdy=%0b exp=15/0/1", count, alloc_idx, alloc_ready); end
        commit_ready = 1'b0;
        tick();
        idle();
        src_idx = {4'd0, 4'd0};
        #1;
        total++; if (count !== 5'd16 || alloc_idx !== 4'd1 || src_done[0] !== 1'b0) begin bad++; $display("FAIL full_wrap_alloc got cnt=%0d idx=%0d done0=%0b exp=16/1/0", count, alloc_idx, src_done[0]); end
    endtask

    task automatic test_flush();
        do_reset();
        fill(5);
        flush         = 1'b1;
        alloc_valid   = 1'b1;
        alloc_rd_addr = 5'd7;
        cdb_valid     = 2'b01;
        cdb_rob_idx   = {4'd0, 4'd1};
        cdb_data      = {32'h0, 32'h0000_0099};
        tick();
        idle();
        total++; if (count !== 5'd0 || alloc_idx !== 4'd0 || commit_valid !== 1'b0) begin bad++; $display("FAIL flush_state got cnt=%0d idx=%0d cv=%0b exp=0/0/0", count, alloc_idx, commit_valid); end
        cdb_valid   = 2'b01;
        cdb_rob_idx = {4'd0, 4'd1};
        cdb_data    = {32'h0, 32'h0000_1234};
        tick();
        idle();
        src_idx = {4'd1, 4'd1};
        #1;
        total++; if (src_done !== 2'b00 || count !== 5'd0 || commit_valid !== 1'b0) begin bad++; $display("FAIL flush_stale_cdb got done=%0b cnt=%0d cv=%0b exp=0/0/0", src_done, count, commit_valid); end
    endtask

    task automatic test_lookup();
        bit exp_now;
        do_reset();
        fill(6);
        src_idx     = {4'd5, 4'd5};
        cdb_valid   = 2'b01;
        cdb_rob_idx = {4'd0, 4'd5};
        cdb_data    = {32'h0, 32'h0000_DEAD};
        #1;
`ifdef ROB_CDB_BYPASS_EN
        exp_now = 1'b1;
`else
        exp_now = 1'b0;
`endif
        total++; if (src_done !== {exp_now, exp_now}) begin bad++; $display("FAIL lookup_same_cycle got=%0b exp=%0b", src_done, {exp_now, exp_now}); end
        if (exp_now) begin
            total++; if (src_data !== {32'hDEAD, 32'hDEAD}) begin bad++; $display("FAIL lookup_bypass_data got=%0h exp=dead", src_data); end
        end
        tick();
        idle();
        total++; if (src_done !== 2'b11 || src_data !== {32'hDEAD, 32'hDEAD}) begin bad++; $display("FAIL lookup_next_cycle got done=%0b d=%0h exp=11/dead", src_done, src_data); end
    endtask

    task automatic test_random();
        int          pos;
        int          si;
        bit          exp_d;
        logic [31:0] exp_dat;
        bit          exp_cv;
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            alloc_valid   = ($urandom_range(0, 9) < 6);
            alloc_rd_addr = 5'($urandom);
            alloc_op_type = 3'($urandom_range(0, 5));
            commit_ready  = ($urandom_range(0, 9) < 7);
            flush         = ($urandom_range(0, 63) == 0);
            for (int p = 0; p < CDB_PORTS; p++) begin
                cdb_valid[p] = ($urandom_range(0, 2) != 0);
                if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                    cdb_rob_idx[p*IDX_W +: IDX_W] = 4'(mq[$urandom_range(0, mq.size() - 1)].idx);
                else
                    cdb_rob_idx[p*IDX_W +: IDX_W] = 4'($urandom);
                cdb_data[p*32 +: 32] = $urandom;
            end
            src_idx = 8'($urandom);
            #1;
            total++; if (alloc_ready !== (mq.size() < DEPTH)) begin bad++; $display("FAIL rnd_alloc_ready cyc=%0d got=%0b exp=%0b", cyc, alloc_ready, mq.size() < DEPTH); end
            total++; if (alloc_idx !== 4'(m_tail % DEPTH)) begin bad++; $display("FAIL rnd_alloc_idx cyc=%0d got=%0d exp=%0d", cyc, alloc_idx, m_tail % DEPTH); end
            total++; if (count !== 5'(mq.size())) begin bad++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count, mq.size()); end
            exp_cv = (mq.size() > 0) && mq[0].done;
            total++; if (commit_valid !== exp_cv) begin bad++; $display("FAIL rnd_commit_valid cyc=%0d got=%0b exp=%0b", cyc, commit_valid, exp_cv); end
            if (exp_cv) begin
                total++;
                if (commit_rob_idx !== 4'(mq[0].idx) || commit_rd_addr !== mq[0].rd || commit_rd_data !== mq[0].data) begin
                    bad++;
                    $display("FAIL rnd_commit_fields cyc=%0d got=%0d/%0d/%0h exp=%0d/%0d/%0h", cyc, commit_rob_idx, commit_rd_addr, commit_rd_data, mq[0].idx, mq[0].rd, mq[0].data);
                end
            end
            for (int k = 0; k < 2; k++) begin
                si      = int'(src_idx[k*IDX_W +: IDX_W]);
                pos     = m_find(si);
                exp_d   = (pos >= 0) && mq[pos].done;
                exp_dat = (pos >= 0) ? mq[pos].data : 32'h0;
`ifdef ROB_CDB_BYPASS_EN
                for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                    if (cdb_valid[p] && int'(cdb_rob_idx[p*IDX_W +: IDX_W]) == si && pos >= 0) begin
                        exp_d   = 1'b1;
                        exp_dat = cdb_data[p*32 +: 32];
                    end
                end
`endif
                total++; if (src_done[k] !== exp_d) begin bad++; $display("FAIL rnd_src_done%0d cyc=%0d got=%0b exp=%0b", k, cyc, src_done[k], exp_d); end
                if (exp_d) begin
                    total++; if (src_data[k*32 +: 32] !== exp_dat) begin bad++; $display("FAIL rnd_src_data%0d cyc=%0d got=%0h exp=%0h", k, cyc, src_data[k*32 +: 32], exp_dat); end
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fill();
        test_out_of_order();
        test_same_index();
        test_full_commit_alloc();
        test_flush();
        test_lookup();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
